// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war playfield controller.
package tug_pkg;

    localparam int NUM_LEDS = 9;
    localparam int CENTER   = 4;
    localparam int POS_W    = 4;

    localparam logic [POS_W-1:0] POS_LEFT_END  = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0] POS_RIGHT_END = '0;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        HOLD_L = 2'd1,
        HOLD_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    // One-hot light pattern for a light position.
    function automatic logic [NUM_LEDS-1:0] pos_to_leds(input logic [POS_W-1:0] p);
        logic [NUM_LEDS-1:0] one;
        one = {{(NUM_LEDS - 1){1'b0}}, 1'b1};
        return one << p;
    endfunction

endpackage

// File: rtl/tug_field_score_counter.sv
// Saturating per-player round counter with increment enable.
module score_counter
    import tug_pkg::*;
#(
    parameter int W   = 3,
    parameter int MAX = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step on enable, pinned at MAX so it can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/tug_field.sv
// Two-player tug-of-war: a light walks toward whoever is out-pressing the
// other; pushing it off an end wins the round, the field goes dark for a
// hold period, and the game stops once a player reaches MAX_SCORE.
module tug_field
    import tug_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int MAX_SCORE   = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                l_press,
    input  logic                r_press,
    output logic [NUM_LEDS-1:0] leds,
    output logic [2:0]          l_score,
    output logic [2:0]          r_score,
    output logic [1:0]          winner,
    output logic                game_over
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_t              state_q;
    logic [POS_W-1:0]    pos_q;
    logic [NUM_LEDS-1:0] leds_q;
    logic [1:0]          winner_q;
    logic                game_over_q;
    logic [HOLD_W-1:0]   hold_q;

    logic                l_only;
    logic                r_only;
    logic                l_win_d;
    logic                r_win_d;
    logic [2:0]          win_score;

    // Lone presses and round-win detection; these also drive the score counters.
    always_comb begin
        l_only    = l_press & ~r_press;
        r_only    = r_press & ~l_press;
        l_win_d   = (state_q == PLAY) && l_only && (pos_q == POS_LEFT_END);
        r_win_d   = (state_q == PLAY) && r_only && (pos_q == POS_RIGHT_END);
        win_score = (state_q == HOLD_L) ? l_score : r_score;
    end

    // Game FSM with registered light, winner and game-over outputs.
    // game_over rises when the final round's hold completes and DONE is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= PLAY;
            pos_q       <= POS_W'(CENTER);
            leds_q      <= pos_to_leds(POS_W'(CENTER));
            winner_q    <= WIN_NONE;
            game_over_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (l_win_d) begin
                        state_q  <= HOLD_L;
                        leds_q   <= '0;
                        winner_q <= WIN_LEFT;
                        hold_q   <= '0;
                    end else if (r_win_d) begin
                        state_q  <= HOLD_R;
                        leds_q   <= '0;
                        winner_q <= WIN_RIGHT;
                        hold_q   <= '0;
                    end else if (l_only) begin
                        pos_q  <= pos_q + POS_W'(1);
                        leds_q <= pos_to_leds(pos_q + POS_W'(1));
                    end else if (r_only) begin
                        pos_q  <= pos_q - POS_W'(1);
                        leds_q <= pos_to_leds(pos_q - POS_W'(1));
                    end
                end
                HOLD_L, HOLD_R: begin
                    if (hold_q == HOLD_LAST) begin
                        if (win_score == 3'(MAX_SCORE)) begin
                            state_q     <= DONE;
                            game_over_q <= 1'b1;
                        end else begin
                            state_q  <= PLAY;
                            pos_q    <= POS_W'(CENTER);
                            leds_q   <= pos_to_leds(POS_W'(CENTER));
                            winner_q <= WIN_NONE;
                        end
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_q <= DONE;
                end
            endcase
        end
    end

    score_counter #(.W(3), .MAX(MAX_SCORE)) u_l_score (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (l_win_d),
        .count_o (l_score)
    );

    score_counter #(.W(3), .MAX(MAX_SCORE)) u_r_score (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (r_win_d),
        .count_o (r_score)
    );

    assign leds      = leds_q;
    assign winner    = winner_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_tug_field.sv
// Self-checking bench for tug_field: directed scenarios plus a random
// press phase, all compared against a round-level game model.
module tb_tug_field;

    localparam int HOLD = 8;
    localparam int MAXS = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       l_press = 1'b0;
    logic       r_press = 1'b0;
    logic [8:0] leds;
    logic [2:0] l_score;
    logic [2:0] r_score;
    logic [1:0] winner;
    logic       game_over;

    int n_chk = 0;
    int n_pass = 0;

    // Game model: phase 0 = play, 1 = dark hold, 2 = finished.
    int m_pos, m_l, m_r, m_win, m_rem, m_phase;
    bit m_over;

    tug_field #(.HOLD_CYCLES(HOLD), .MAX_SCORE(MAXS)) dut (
        .clk       (clk),
        .reset     (reset),
        .l_press   (l_press),
        .r_press   (r_press),
        .leds      (leds),
        .l_score   (l_score),
        .r_score   (r_score),
        .winner    (winner),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        m_pos = 4; m_l = 0; m_r = 0; m_win = 0; m_rem = 0; m_phase = 0; m_over = 1'b0;
    endtask

    task automatic m_step(input bit l, input bit r);
        if (m_phase == 0) begin
            if (l && !r) begin
                if (m_pos == 8) begin
                    m_l++; m_win = 1; m_phase = 1; m_rem = HOLD;
                end else m_pos++;
            end else if (r && !l) begin
                if (m_pos == 0) begin
                    m_r++; m_win = 2; m_phase = 1; m_rem = HOLD;
                end else m_pos--;
            end
        end else if (m_phase == 1) begin
            m_rem--;
            if (m_rem == 0) begin
                if (((m_win == 1) ? m_l : m_r) == MAXS) begin
                    m_phase = 2; m_over = 1'b1;
                end else begin
                    m_phase = 0; m_pos = 4; m_win = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_all(input string tag);
        logic [8:0] one;
        logic [8:0] exp_leds;
        one = 9'd1;
        exp_leds = (m_phase == 0) ? (one << m_pos) : 9'd0;
        chk({tag, ".leds"}, 32'(leds), 32'(exp_leds));
        chk({tag, ".l_score"}, 32'(l_score), 32'(m_l));
        chk({tag, ".r_score"}, 32'(r_score), 32'(m_r));
        chk({tag, ".winner"}, 32'(winner), 32'(m_win));
        chk({tag, ".game_over"}, 32'(game_over), 32'(m_over));
    endtask

    task automatic cycle(input bit l, input bit r, input string tag);
        @(negedge clk);
        l_press = l;
        r_press = r;
        @(posedge clk);
        m_step(l, r);
        #1;
        check_all(tag);
    endtask

    // Reset pulse asserted between edges; outputs checked before any edge.
    task automatic rst_pulse(input string tag);
        #1;
        reset = 1'b1;
        l_press = 1'b0;
        r_press = 1'b0;
        #1;
        m_reset();
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [8:0] walk [5];
        int n;
        int bias;
        bit lr, rr;

        walk[0] = 9'h020; walk[1] = 9'h040; walk[2] = 9'h080; walk[3] = 9'h100; walk[4] = 9'h000;

        // Reset with no clock edge yet.
        rst_pulse("reset");
        chk("reset.leds_const", 32'(leds), 32'h010);

        // Left walks off the left end.
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b0, "lwin");
            chk("lwin.walk", 32'(leds), 32'(walk[k]));
        end
        chk("lwin.winner", 32'(winner), 32'd1);
        chk("lwin.l_score", 32'(l_score), 32'd1);
        n = 0;
        while (leds === 9'd0 && n < 40) begin
            cycle(1'b0, 1'b0, "lhold");
            n++;
        end
        chk("lwin.hold_len", 32'(n), 32'(HOLD));
        chk("lwin.back_center", 32'(leds), 32'h010);

        // Simultaneous presses leave the light in place.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b1, "both");
            chk("both.leds", 32'(leds), 32'h010);
        end

        // Right presses during a left hold are ignored.
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, "mask_walk");
        n = 0;
        while (leds === 9'd0 && n < 40) begin
            cycle(1'b0, (n % 2) == 0, "mask_hold");
            n++;
        end
        chk("mask.hold_len", 32'(n), 32'(HOLD));
        chk("mask.l_score", 32'(l_score), 32'd2);
        chk("mask.r_score", 32'(r_score), 32'd0);

        // Random play with occasional asynchronous resets.
        rst_pulse("rnd_rst");
        for (int i = 0; i < 400; i++) begin
            bias = (((i / 50) % 2) == 0) ? 55 : 15;
            lr = ($urandom_range(0, 99) < bias);
            rr = ($urandom_range(0, 99) < (70 - bias));
            cycle(lr, rr, "rnd");
            if ($urandom_range(0, 99) < 2) rst_pulse("rnd_async");
        end

        // Seven left wins end the game.
        rst_pulse("go_rst");
        for (int rnd = 0; rnd < MAXS; rnd++) begin
            for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, "go_walk");
            for (int k = 0; k < HOLD; k++) cycle(1'b0, 1'b0, "go_hold");
        end
        chk("go.l_score", 32'(l_score), 32'd7);
        chk("go.game_over", 32'(game_over), 32'd1);
        chk("go.winner", 32'(winner), 32'd1);
        chk("go.leds", 32'(leds), 32'd0);
        for (int k = 0; k < 20; k++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "go_idle");
        end
        chk("go.l_score_held", 32'(l_score), 32'd7);
        rst_pulse("go_reset");
        chk("go_reset.game_over", 32'(game_over), 32'd0);
        chk("go_reset.leds", 32'(leds), 32'h010);

        // Asynchronous reset with the light at position 7.
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, "mid_walk");
        chk("mid.pos7", 32'(leds), 32'h080);
        rst_pulse("mid_rst");
        chk("mid.leds", 32'(leds), 32'h010);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
